// File: rtl/rv32i_pkg.sv
// Constants shared across the RV32I pipeline: NOP encoding, the fetch FSM state type and the
// base opcodes used by decode and hazard detection.
package rv32i_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    StBoot,
    StFetch,
    StHold,
    StDrain
  } fetch_state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register. A bubble load takes priority over a normal write; reset leaves a
// bubble in place.
module if_id_register
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        write_en,
  input  logic        bubble,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic [31:0] instr,
  output logic        valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= '0;
      pc4   <= '0;
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (bubble) begin
      pc    <= '0;
      pc4   <= '0;
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (write_en) begin
      pc    <= load_pc;
      pc4   <= load_pc + 32'd4;
      instr <= load_instr;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// RV32I fetch stage: PC register, req/ready instruction-memory handshake and IF/ID control.
// Absorbs memory wait states, hazard stalls and ID-stage redirects without losing instructions.
module instruction_fetch_stage
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        IF_IDWrite,
  input  logic        ID_redirect,
  input  logic [31:0] ID_redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_pc,
  output logic [31:0] IF_ID_pc4,
  output logic [31:0] IF_ID_instr,
  output logic        IF_ID_valid
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  hold_buf_q;
  logic [31:0]  redir_pc_q;

  logic        stall;
  logic        redir;
  logic [31:0] target;
  logic        ifid_load;
  logic        ifid_bubble;
  logic [31:0] ifid_instr;

  assign stall  = !IF_IDWrite || !PCWrite;
  assign redir  = ID_redirect && !stall;
  assign target = ID_redirect_target & 32'hFFFF_FFFC;

  // Request outputs depend on registers only; in DRAIN pc_q still holds the in-flight address.
  assign imem_req  = (state_q == StFetch) || (state_q == StDrain);
  assign imem_addr = pc_q;

  always_comb begin
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_instr  = imem_rdata;
    unique case (state_q)
      StFetch: begin
        if (redir) begin
          ifid_bubble = 1'b1;
        end else if (imem_ready && !stall) begin
          ifid_load = 1'b1;
        end else if (!imem_ready && !stall) begin
          ifid_bubble = 1'b1;
        end
      end
      StHold: begin
        if (redir) begin
          ifid_bubble = 1'b1;
        end else if (!stall) begin
          ifid_load  = 1'b1;
          ifid_instr = hold_buf_q;
        end
      end
      StDrain: begin
        ifid_bubble = !stall;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StBoot;
      pc_q       <= RESET_PC;
      hold_buf_q <= '0;
      redir_pc_q <= '0;
    end else begin
      case (state_q)
        StBoot: state_q <= StFetch;
        StFetch: begin
          if (redir) begin
            if (imem_ready) begin
              pc_q <= target;
            end else begin
              redir_pc_q <= target;
              state_q    <= StDrain;
            end
          end else if (imem_ready) begin
            if (stall) begin
              hold_buf_q <= imem_rdata;
              state_q    <= StHold;
            end else begin
              pc_q <= pc_q + 32'd4;
            end
          end
        end
        StHold: begin
          if (redir) begin
            pc_q    <= target;
            state_q <= StFetch;
          end else if (!stall) begin
            pc_q    <= pc_q + 32'd4;
            state_q <= StFetch;
          end
        end
        StDrain: begin
          // The in-flight response is discarded; a redirect arriving with it wins.
          if (imem_ready) begin
            pc_q    <= redir ? target : redir_pc_q;
            state_q <= StFetch;
          end else if (redir) begin
            redir_pc_q <= target;
          end
        end
        default: state_q <= StBoot;
      endcase
    end
  end

  if_id_register u_if_id (
    .clk        (clk),
    .rst        (rst),
    .write_en   (ifid_load),
    .bubble     (ifid_bubble),
    .load_pc    (pc_q),
    .load_instr (ifid_instr),
    .pc         (IF_ID_pc),
    .pc4        (IF_ID_pc4),
    .instr      (IF_ID_instr),
    .valid      (IF_ID_valid)
  );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: instruction-stream model checked every cycle plus
// directed scenarios with literal expectations.
module tb_instruction_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        PCWrite = 1'b1;
  logic        IF_IDWrite = 1'b1;
  logic        ID_redirect = 1'b0;
  logic [31:0] ID_redirect_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] IF_ID_pc;
  logic [31:0] IF_ID_pc4;
  logic [31:0] IF_ID_instr;
  logic        IF_ID_valid;

  int waits = 0;
  int wcnt = 0;
  int n_tests = 0;
  int n_fail = 0;

  instruction_fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk                (clk),
    .rst                (rst),
    .PCWrite            (PCWrite),
    .IF_IDWrite         (IF_IDWrite),
    .ID_redirect        (ID_redirect),
    .ID_redirect_target (ID_redirect_target),
    .imem_req           (imem_req),
    .imem_addr          (imem_addr),
    .imem_ready         (imem_ready),
    .imem_rdata         (imem_rdata),
    .IF_ID_pc           (IF_ID_pc),
    .IF_ID_pc4          (IF_ID_pc4),
    .IF_ID_instr        (IF_ID_instr),
    .IF_ID_valid        (IF_ID_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  // Memory: answers after 'waits' wait cycles, word derived from address.
  assign imem_rdata = mem_word(imem_addr);
  assign imem_ready = imem_req && (wcnt == waits);

  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 0;
    else if (imem_req && !imem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: next address to deliver, optional buffered word, optional pending flush.
  logic [31:0] m_pc, m_flush_pc;
  logic        m_booting, m_have_word, m_flush;
  logic [31:0] e_pc, e_pc4, e_instr;
  logic        e_valid;

  task automatic bubble();
    e_pc = '0; e_pc4 = '0; e_instr = NOP; e_valid = 1'b0;
  endtask

  task automatic deliver();
    e_pc = m_pc; e_pc4 = m_pc + 32'd4; e_instr = mem_word(m_pc); e_valid = 1'b1;
    m_pc = m_pc + 32'd4;
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_flush_pc = '0;
    m_booting = 1'b1; m_have_word = 1'b0; m_flush = 1'b0;
    bubble();
  endtask

  task automatic model_step();
    logic        stl, rd;
    logic [31:0] tgt;
    stl = !IF_IDWrite || !PCWrite;
    rd  = ID_redirect && !stl;
    tgt = ID_redirect_target & 32'hFFFF_FFFC;
    if (m_booting) begin
      m_booting = 1'b0;
    end else if (m_have_word) begin
      if (rd) begin
        m_have_word = 1'b0; m_pc = tgt; bubble();
      end else if (!stl) begin
        deliver(); m_have_word = 1'b0;
      end
    end else if (m_flush) begin
      if (!stl) bubble();
      if (rd) m_flush_pc = tgt;
      if (imem_ready) begin
        m_pc = m_flush_pc; m_flush = 1'b0;
      end
    end else if (rd) begin
      bubble();
      if (imem_ready) m_pc = tgt;
      else begin
        m_flush = 1'b1; m_flush_pc = tgt;
      end
    end else if (imem_ready) begin
      if (stl) m_have_word = 1'b1;
      else deliver();
    end else if (!stl) begin
      bubble();
    end
  endtask

  logic [31:0] prev_addr = '0;
  logic        prev_wait = 1'b0;

  always @(negedge clk) begin
    if (rst) model_reset();
    chk("req", 32'(imem_req), 32'(!m_booting && !m_have_word));
    if (!m_booting && !m_have_word) chk("addr", imem_addr, m_pc);
    if (prev_wait && !rst) chk("addr_stable", imem_addr, prev_addr);
    chk("ifid_pc", IF_ID_pc, e_pc);
    chk("ifid_pc4", IF_ID_pc4, e_pc4);
    chk("ifid_instr", IF_ID_instr, e_instr);
    chk("ifid_valid", 32'(IF_ID_valid), 32'(e_valid));
    prev_wait = imem_req && !imem_ready && !rst;
    prev_addr = imem_addr;
    if (!rst) model_step();
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int vcount;

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("lit_boot_req", 32'(imem_req), 32'd0);
    step();
    chk("lit_first_addr", imem_addr, 32'h100);
    step();
    chk("lit_first_ifid", IF_ID_pc, 32'h100);
    chk("lit_first_valid", 32'(IF_ID_valid), 32'd1);
    chk("lit_addr_104", imem_addr, 32'h104);
    step();
    chk("lit_addr_108", imem_addr, 32'h108);
    chk("lit_ifid_104", IF_ID_pc, 32'h104);
    // Stall while 0x108 is being returned.
    PCWrite = 1'b0; IF_IDWrite = 1'b0;
    step();
    chk("lit_hold_req", 32'(imem_req), 32'd0);
    chk("lit_hold_ifid", IF_ID_pc, 32'h104);
    step(); step();
    chk("lit_hold_ifid2", IF_ID_pc, 32'h104);
    PCWrite = 1'b1; IF_IDWrite = 1'b1;
    step();
    chk("lit_release_pc", IF_ID_pc, 32'h108);
    chk("lit_release_instr", IF_ID_instr, 32'hC0DE_0108);
    chk("lit_release_addr", imem_addr, 32'h10C);
    // Zero-wait redirect, misaligned target.
    ID_redirect = 1'b1; ID_redirect_target = 32'h203;
    step();
    ID_redirect = 1'b0;
    chk("lit_redir_addr", imem_addr, 32'h200);
    chk("lit_redir_bubble", 32'(IF_ID_valid), 32'd0);
    step();
    chk("lit_redir_pc", IF_ID_pc, 32'h200);
    chk("lit_redir_instr", IF_ID_instr, 32'hC0DE_0200);
    chk("lit_redir_next", imem_addr, 32'h204);
    // Two wait states per fetch.
    waits = 2;
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      chk("lit_wait_addr", imem_addr, 32'h204 + 32'(4 * (i / 3)));
      if (IF_ID_valid) vcount++;
      step();
    end
    chk("lit_wait_valid_cnt", 32'(vcount), 32'd2);
    chk("lit_wait_addr_20c", imem_addr, 32'h20C);
    // Redirect into DRAIN, then a second redirect while 0x110 is waiting.
    ID_redirect = 1'b1; ID_redirect_target = 32'h110;
    step();
    ID_redirect = 1'b0;
    chk("lit_drain_addr", imem_addr, 32'h20C);
    step();
    step();
    chk("lit_addr_110", imem_addr, 32'h110);
    ID_redirect = 1'b1; ID_redirect_target = 32'h400;
    step();
    ID_redirect = 1'b0;
    chk("lit_drain110_addr", imem_addr, 32'h110);
    chk("lit_drain110_req", 32'(imem_req), 32'd1);
    step();
    chk("lit_drain110_addr2", imem_addr, 32'h110);
    step();
    chk("lit_addr_400", imem_addr, 32'h400);
    chk("lit_drain_bubble", 32'(IF_ID_valid), 32'd0);
    step(); step(); step();
    chk("lit_ifid_400", IF_ID_pc, 32'h400);
    chk("lit_instr_400", IF_ID_instr, 32'hC0DE_0400);
    // Redirect during stall is ignored.
    waits = 0; IF_IDWrite = 1'b0; ID_redirect = 1'b1; ID_redirect_target = 32'h500;
    step();
    chk("lit_stallredir_req", 32'(imem_req), 32'd0);
    chk("lit_stallredir_ifid", IF_ID_pc, 32'h400);
    step();
    chk("lit_stallredir_ifid2", IF_ID_pc, 32'h400);
    IF_IDWrite = 1'b1; ID_redirect = 1'b0;
    step();
    chk("lit_after_stall_pc", IF_ID_pc, 32'h404);
    chk("lit_after_stall_addr", imem_addr, 32'h408);
    // Reset asserted while draining.
    waits = 3; ID_redirect = 1'b1; ID_redirect_target = 32'h600;
    step();
    ID_redirect = 1'b0;
    chk("lit_pre_rst_addr", imem_addr, 32'h408);
    chk("lit_pre_rst_req", 32'(imem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("lit_rst_req", 32'(imem_req), 32'd0);
    chk("lit_rst_valid", 32'(IF_ID_valid), 32'd0);
    chk("lit_rst_instr", IF_ID_instr, NOP);
    chk("lit_rst_pc", IF_ID_pc, 32'd0);
    chk("lit_rst_pc4", IF_ID_pc4, 32'd0);
    chk("lit_rst_addr", imem_addr, 32'h100);
    @(posedge clk);
    #1 rst = 1'b0; waits = 0;
    chk("lit_reboot_req", 32'(imem_req), 32'd0);
    step();
    chk("lit_refetch_addr", imem_addr, 32'h100);
    step();
    chk("lit_refetch_ifid", IF_ID_pc, 32'h100);
    repeat (4) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Instruction-fetch stage of the pipelined RV32I core: owns the PC register, issues requests to instruction memory over a req/ready handshake, and drives the IF/ID pipeline register. It sits directly upstream of the decode-stage hazard logic. It consumes that logic's `PCWrite`/`IF_IDWrite` stall controls and the ID-stage branch/jump redirect. It absorbs memory wait states, stalls and redirects, so no instruction is lost or duplicated.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `PCWrite` in 1: 0 = hold PC (hazard stall).
- `IF_IDWrite` in 1: 0 = hold IF/ID register contents (hazard stall).
- `ID_redirect` in 1: taken branch/JAL/JALR resolved in ID this cycle.
- `ID_redirect_target` in 32: redirect address.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: fetch address; stable while `imem_req`=1 and `imem_ready`=0.
- `imem_ready` in 1: response valid this cycle; completes the request.
- `imem_rdata` in 32: instruction word, valid when `imem_ready`=1.
- `IF_ID_pc` out 32: PC of the instruction in IF/ID.
- `IF_ID_pc4` out 32: `IF_ID_pc`+4.
- `IF_ID_instr` out 32: instruction word (NOP 32'h0000_0013 when invalid).
- `IF_ID_valid` out 1: IF/ID holds a real instruction.

## Operation
- Stall definition: `stall` = !`IF_IDWrite` || !`PCWrite`. The hazard unit drives both controls together, but either one alone also stalls.
- Qualified redirect: `redir` = `ID_redirect` && !`stall`. A redirect during a stall is ignored; ID re-asserts it after the stall.
- The redirect target has bits [1:0] forced to 00. No misalignment trap is raised.
- Bubble: IF/ID loads {pc=0, pc4=0, instr=NOP, valid=0}.
- FSM states: BOOT, FETCH, HOLD, DRAIN.
  - BOOT (reset state): `imem_req`=0. Next state is FETCH.
  - FETCH: `imem_req`=1, `imem_addr`=pc.
    - `redir` && !`imem_ready`: latch target into `redir_pc`, load bubble, go to DRAIN.
    - `redir` && `imem_ready`: discard rdata, pc<=target, load bubble, stay in FETCH.
    - `imem_ready` && !`stall`: IF/ID<={pc, pc+4, rdata, 1}, pc<=pc+4.
    - `imem_ready` && `stall`: rdata goes into `hold_buf`, IF/ID held, go to HOLD.
    - !`imem_ready` && !`stall`: load bubble, pc held.
    - !`imem_ready` && `stall`: everything held.
  - HOLD: `imem_req`=0.
    - `redir`: drop `hold_buf`, pc<=target, load bubble, go to FETCH.
    - !`stall`: IF/ID<={pc, pc+4, `hold_buf`, 1}, pc<=pc+4, go to FETCH.
    - Otherwise hold.
  - DRAIN: `imem_req`=1, `imem_addr`=old pc, kept stable per the handshake rule.
    - On `imem_ready`: discard rdata, pc<=`redir_pc`, go to FETCH.
    - IF/ID follows stall: held when stalled, bubble otherwise.
    - A further `redir` overwrites `redir_pc`.
- PC arithmetic: 32-bit, wraps from 32'hFFFF_FFFC to 0 silently.
- Reset values (asynchronous, immediate): state=BOOT, pc=`RESET_PC`, `imem_req`=0, `IF_ID_valid`=0, `IF_ID_instr`=NOP, `IF_ID_pc`=0, `IF_ID_pc4`=0, `hold_buf`=0, `redir_pc`=0.
- Reset mid-request abandons the transaction. Instruction memory must tolerate a dropped request.

## Timing
- `imem_req` and `imem_addr` decode only from state and pc registers. There are no combinational paths from inputs.
- Reset release: cycle 0 is BOOT. The first request goes out in cycle 1. With zero-wait memory, the first instruction is in IF/ID after the edge ending cycle 1.
- Zero-wait throughput: 1 instruction per cycle.
- Each wait cycle inserts one bubble, unless stalled.
- Redirect penalty: exactly 1 bubble with zero-wait memory. Add the remaining wait cycles of the in-flight request when the redirect arrives in DRAIN.
- Stall release from HOLD: the buffered instruction enters IF/ID on the first non-stalled edge, with no refetch.

## Structure
- Shared package (`rv32i_pkg`):
  - `NOP_INSTR` = 32'h0000_0013.
  - Fetch FSM state enumeration (2 bits).
  - The opcode constants already used by the decode and hazard logic.
- One sub-module: `if_id_register`. It holds the pc/pc4/instr/valid registers, with write-enable and bubble-load inputs, and reset to bubble.
- The PC register, FSM, `hold_buf` and `redir_pc` live in the top module.

## Test plan
- Reset, `RESET_PC`=32'h100, `imem_ready`=1 constantly:
  - `imem_addr` sequence is 0x100, 0x104, 0x108.
  - `IF_ID_pc` shows 0x100 after the edge ending cycle 1.
  - `IF_ID_valid`=1 every cycle after that.
- Two wait states per fetch:
  - `imem_addr` is held for 3 cycles per fetch.
  - 2 bubbles appear per instruction.
  - No PC skips.
- Stall when `imem_ready`=1 at pc 0x108, held 3 cycles:
  - State goes to HOLD and `imem_req`=0.
  - IF/ID stays at 0x104.
  - On release, IF/ID=0x108 with the buffered word, and the next `imem_addr` is 0x10C.
- `ID_redirect` with target 0x203, `imem_ready`=1:
  - Next `imem_addr` is 0x200.
  - Exactly one bubble.
  - Word for 0x200 lands in IF/ID next.
- `ID_redirect` with target 0x400 while a request to 0x110 is waiting:
  - `imem_addr` holds 0x110 until ready, then the response is discarded.
  - Next `imem_addr` is 0x400.
  - The 0x110 word never reaches IF/ID.
- `ID_redirect` together with `IF_IDWrite`=0: the redirect is ignored and PC and IF/ID are unchanged.
- `rst` pulsed mid-DRAIN:
  - `imem_req` falls asynchronously and all outputs take their reset values.
  - Fetch restarts at `RESET_PC`.
